// File: rtl/imem_loader.sv
// imem_loader: boots a core from a byte stream.
//   Collects little-endian program bytes into 32-bit words and writes them
//   to instruction memory. The halt word (opcode 7'h7F) ends loading. The
//   loader then releases the core and watches its IF/ID instruction for
//   the halt. A watchdog timer moves to an error state if the halt never
//   arrives.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active low
//   s_valid/s_data byte stream input (8-bit)
//   s_ready        loader can take a byte this cycle
//   imem_we        one-cycle write strobe to instruction memory
//   imem_addr      word address of the write (ADDR_W bits)
//   imem_wdata     assembled instruction word (32 bits)
//   if_instruction instruction currently in the core's IF/ID register
//   core_rst       active-high reset to the core
//   core_enable    core run enable
//   done           core fetched the halt instruction (sticky until reset)
//   load_err       overflow or run timeout (sticky until reset)
//   words_loaded   number of words written (ADDR_W+1 bits)
//
// state | meaning
// LOAD  | accepting bytes, core held in reset
// RUN   | core enabled, run counter counting, waiting for halt fetch
// DONE  | halt fetched, core stopped (terminal)
// ERR   | image overflow or run timeout (terminal)
module imem_loader #(
  parameter int ADDR_W      = 8,
  parameter int RUN_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic [31:0]       if_instruction,
  output logic              core_rst,
  output logic              core_enable,
  output logic              done,
  output logic              load_err,
  output logic [ADDR_W:0]   words_loaded
);

  localparam logic [ADDR_W:0] DEPTH    = {1'b1, {ADDR_W{1'b0}}};
  // The run counter reaches RUN_TIMEOUT on the edge where it holds RUN_TIMEOUT-1.
  localparam logic [31:0]     TMO_LAST = 32'(RUN_TIMEOUT - 1);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE, S_ERR} state_t;

  state_t            state, state_nxt;
  logic [1:0]        bcnt;
  logic [23:0]       byte_buf;
  logic [ADDR_W-1:0] word_ptr;
  logic [31:0]       run_cnt;
  logic              xfer, last_byte, word_full, halt_wr, ir_halt;
  logic              unused_ir;

  // While the halt word is being written the loader stops taking bytes,
  // so anything after the halt stays in the source.
  assign halt_wr   = imem_we && (imem_wdata[6:0] == 7'h7F);
  assign s_ready   = (state == S_LOAD) && !halt_wr;
  assign xfer      = s_valid && s_ready;
  assign last_byte = xfer && (bcnt == 2'd3);
  assign word_full = (words_loaded == DEPTH);
  assign ir_halt   = (if_instruction[6:0] == 7'h7F);
  assign unused_ir = ^if_instruction[31:7];

  always_ff @(posedge clk) begin
    if (!rst) state <= S_LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    core_rst    = 1'b1;
    core_enable = 1'b0;
    done        = 1'b0;
    load_err    = 1'b0;
    case (state)
      S_LOAD: begin
        if (halt_wr)                     state_nxt = S_RUN;
        else if (last_byte && word_full) state_nxt = S_ERR;
      end
      S_RUN: begin
        core_rst    = 1'b0;
        core_enable = 1'b1;
        // Halt takes priority over a timeout on the same edge.
        if (ir_halt)                    state_nxt = S_DONE;
        else if (run_cnt == TMO_LAST)   state_nxt = S_ERR;
      end
      S_DONE: begin
        core_rst = 1'b0;
        done     = 1'b1;
      end
      S_ERR: begin
        load_err = 1'b1;
      end
      default: state_nxt = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bcnt         <= 2'd0;
      byte_buf     <= 24'd0;
      word_ptr     <= '0;
      words_loaded <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      run_cnt      <= 32'd0;
    end else begin
      imem_we <= 1'b0;
      if (xfer) begin
        bcnt <= bcnt + 2'd1;
        case (bcnt)
          2'd0: byte_buf[7:0]   <= s_data;
          2'd1: byte_buf[15:8]  <= s_data;
          2'd2: byte_buf[23:16] <= s_data;
          default: begin
            // A full image drops the word; the FSM moves to ERR instead.
            if (!word_full) begin
              imem_we      <= 1'b1;
              imem_wdata   <= {s_data, byte_buf};
              imem_addr    <= word_ptr;
              word_ptr     <= word_ptr + ADDR_W'(1);
              words_loaded <= words_loaded + (ADDR_W+1)'(1);
            end
          end
        endcase
      end
      if (state == S_RUN) run_cnt <= run_cnt + 32'd1;
      else                run_cnt <= 32'd0;
    end
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory word-address width; capacity DEPTH = 2^ADDR_W words.
REQ-002 Parameter RUN_TIMEOUT, default 1000: maximum core run cycles before the error state.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 s_valid  input  1  byte-stream source has a byte.
REQ-006 s_data  input  8  program byte; words arrive little-endian.
REQ-007 s_ready  output  1  loader accepts a byte this cycle.
REQ-008 imem_we  output  1  one-cycle write strobe to instruction memory.
REQ-009 imem_addr  output  ADDR_W  word address for the write.
REQ-010 imem_wdata  output  32  assembled instruction word.
REQ-011 if_instruction  input  32  instruction currently held in the core's IF/ID register.
REQ-012 core_rst  output  1  active-high reset to the core.
REQ-013 core_enable  output  1  core run enable.
REQ-014 done  output  1  core fetched the halt instruction.
REQ-015 load_err  output  1  overflow or timeout error, sticky.
REQ-016 words_loaded  output  ADDR_W+1  count of words written.

Function
REQ-017 States SHALL be LOAD, RUN, DONE and ERR; reset enters LOAD.
REQ-018 A byte transfers on a rising edge when s_valid=1 and s_ready=1; no transfer occurs otherwise.
REQ-019 s_ready SHALL be 1 in LOAD and 0 in RUN, DONE and ERR, and during the cycle in which a halt word is written.
REQ-020 Bytes SHALL be assembled with byte k (k=0..3) placed at bits [8k+7:8k], using a 2-bit byte counter that wraps 3->0.
REQ-021 On the edge that accepts byte 3, the registered outputs SHALL drive imem_we=1, imem_wdata=word and imem_addr=word_ptr for exactly one cycle; latency from the 4th byte is 1 cycle.
REQ-022 word_ptr and words_loaded SHALL increment on each write; a new word's bytes SHALL be accepted during the write cycle.
REQ-023 Halt word: assembled word[6:0]==7'h7F; it SHALL be written to memory, and the state SHALL move to RUN on the edge following its write cycle.
REQ-024 Overflow: a 4th byte arriving when words_loaded==DEPTH and the last written word was not a halt word SHALL cause no write and SHALL move the state to ERR.
REQ-025 In LOAD and ERR: core_rst=1 and core_enable=0. In RUN: core_rst=0 and core_enable=1. In DONE: core_rst=0 and core_enable=0.
REQ-026 In RUN, a 32-bit run counter SHALL increment every cycle, starting at 0 on RUN entry.
REQ-027 RUN->DONE SHALL occur on the first edge where if_instruction[6:0]==7'h7F; done=1 from the next cycle and stays 1 until reset.
REQ-028 RUN->ERR SHALL occur when the run counter reaches RUN_TIMEOUT with no halt; if halt and timeout occur on the same edge, DONE SHALL win.
REQ-029 ERR and DONE are terminal; only reset exits them.
REQ-030 Partial words (1-3 bytes) left in LOAD SHALL never be written.

Reset
REQ-031 When rst=0 at a rising edge, all state SHALL clear regardless of current state, including mid-word and mid-run.
REQ-032 Outputs after a reset edge: state=LOAD, s_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, core_enable=0, done=0, load_err=0, words_loaded=0, byte counter=0, run counter=0.
REQ-033 While rst=0, no byte transfer and no memory write SHALL occur.

Verification
REQ-034 Stream 93 00 50 00 then 7F 00 00 00 -> writes 0x00500093 at addr 0 and 0x0000007F at addr 1, each a single-cycle strobe; words_loaded=2; RUN entered 2 cycles after the last byte; core_enable=1.
REQ-035 In RUN, drive if_instruction=0x00500093 for 5 cycles, then 0x0000007F -> done=1 and core_enable=0 one cycle later; s_ready stays 0.
REQ-036 With ADDR_W=2, stream 5 non-halt words -> 4 writes (addr 0-3); 5th word causes no write; load_err=1, core_rst stays 1.
REQ-037 RUN_TIMEOUT=10 with no halt on if_instruction -> ERR after 10 RUN cycles: load_err=1, core_enable=0.
REQ-038 Assert rst=0 after 2 bytes of a word, then stream a full word -> the word is written at addr 0 with bytes from the new stream only.
REQ-039 Toggle s_valid 1/0 each cycle across a word -> identical imem_wdata to the continuous case; no byte is dropped or duplicated.
